psum_accum: RTL

- Read-modify-write accumulator sitting directly upstream of the synchronous psum memory.
- Accepts pairs of partial sums from the PE array over a valid/ready handshake.
- For each pair it reads the two stored psums through the memory's dual read port, adds the new values, and writes the results back through the dual write port.
- A first-pass flag skips the read so the psum buffer is initialised with no separate clear.

---
 rtl/psum_accum.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/psum_accum.sv
// Read-modify-write accumulator in front of the dual-port psum memory.
// Optional clamping of results is enabled by defining PSUM_SAT_EN.
module psum_accum #(
    parameter int IN_WIDTH   = 8,
    parameter int PSUM_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_first,
    input  logic                  i_last,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [IN_WIDTH-1:0]   i_psum0,
    input  logic [IN_WIDTH-1:0]   i_psum1,
    output logic                  o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] o_mem_rd_addr0,
    output logic [ADDR_WIDTH-1:0] o_mem_rd_addr1,
    input  logic [PSUM_WIDTH-1:0] i_mem_rd_data0,
    input  logic [PSUM_WIDTH-1:0] i_mem_rd_data1,
    output logic                  o_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] o_mem_wr_addr0,
    output logic [ADDR_WIDTH-1:0] o_mem_wr_addr1,
    output logic [PSUM_WIDTH-1:0] o_mem_wr_data0,
    output logic [PSUM_WIDTH-1:0] o_mem_wr_data1,
    output logic                  o_done,
    output logic [CNT_WIDTH-1:0]  o_pair_cnt
);

    // Two guard bits hold rd_data + psum0 + psum1 without overflow.
    localparam int SUM_W = PSUM_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    first_q, first_d;
    logic                    last_q, last_d;
    logic [ADDR_WIDTH-1:0]   addr0_q, addr0_d;
    logic [ADDR_WIDTH-1:0]   addr1_q, addr1_d;
    logic [IN_WIDTH-1:0]     psum0_q, psum0_d;
    logic [IN_WIDTH-1:0]     psum1_q, psum1_d;
    logic                    done_q, done_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic                    accept_s;
    logic [SUM_W-1:0]        base0_s, base1_s, sum0_s, sum1_s;
    logic [PSUM_WIDTH-1:0]   res0_s, res1_s;

    function automatic logic [SUM_W-1:0] sext_in(input logic [IN_WIDTH-1:0] v);
        return {{(SUM_W-IN_WIDTH){v[IN_WIDTH-1]}}, v};
    endfunction

    function automatic logic [SUM_W-1:0] sext_ps(input logic [PSUM_WIDTH-1:0] v);
        return {{2{v[PSUM_WIDTH-1]}}, v};
    endfunction

    function automatic logic [PSUM_WIDTH-1:0] reduce(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] hi_lim;
        logic [SUM_W-1:0] lo_lim;
        hi_lim = {3'b000, {(PSUM_WIDTH-1){1'b1}}};
        lo_lim = {3'b111, {(PSUM_WIDTH-1){1'b0}}};
`ifdef PSUM_SAT_EN
        if ($signed(s) > $signed(hi_lim)) begin
            return hi_lim[PSUM_WIDTH-1:0];
        end else if ($signed(s) < $signed(lo_lim)) begin
            return lo_lim[PSUM_WIDTH-1:0];
        end else begin
            return s[PSUM_WIDTH-1:0];
        end
`else
        if (hi_lim == lo_lim) begin
            return {PSUM_WIDTH{1'b0}};
        end else begin
            return s[PSUM_WIDTH-1:0];
        end
`endif
    endfunction

    assign accept_s = i_valid & o_ready;

    // Next-state, capture, done and counter logic.
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        last_d  = last_q;
        addr0_d = addr0_q;
        addr1_d = addr1_q;
        psum0_d = psum0_q;
        psum1_d = psum1_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = i_first ? S_WR : S_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                state_d = S_WR;
            end
            S_WR: begin
                done_d = last_q;
                cnt_d  = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                if (accept_s) begin
                    state_d = i_first ? S_WR : S_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (accept_s) begin
            first_d = i_first;
            last_d  = i_last;
            addr0_d = i_addr0;
            addr1_d = i_addr1;
            psum0_d = i_psum0;
            psum1_d = i_psum1;
        end else begin
            first_d = first_q;
        end
    end

    // Lane sums; on an address collision both lanes carry the combined sum.
    always_comb begin
        base0_s = {SUM_W{1'b0}};
        base1_s = {SUM_W{1'b0}};
        if (!first_q) begin
            base0_s = sext_ps(i_mem_rd_data0);
            base1_s = sext_ps(i_mem_rd_data1);
        end else begin
            base0_s = {SUM_W{1'b0}};
        end
        if (addr0_q == addr1_q) begin
            sum0_s = base0_s + sext_in(psum0_q) + sext_in(psum1_q);
            sum1_s = sum0_s;
        end else begin
            sum0_s = base0_s + sext_in(psum0_q);
            sum1_s = base1_s + sext_in(psum1_q);
        end
        res0_s = reduce(sum0_s);
        res1_s = reduce(sum1_s);
    end

    // State and capture registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            addr0_q <= {ADDR_WIDTH{1'b0}};
            addr1_q <= {ADDR_WIDTH{1'b0}};
            psum0_q <= {IN_WIDTH{1'b0}};
            psum1_q <= {IN_WIDTH{1'b0}};
            done_q  <= 1'b0;
            cnt_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            last_q  <= last_d;
            addr0_q <= addr0_d;
            addr1_q <= addr1_d;
            psum0_q <= psum0_d;
            psum1_q <= psum1_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ready        = (state_q != S_RD);
    assign o_mem_rd_en    = (state_q == S_RD);
    assign o_mem_wr_en    = (state_q == S_WR);
    assign o_mem_rd_addr0 = o_mem_rd_en ? addr0_q : {ADDR_WIDTH{1'b0}};
    assign o_mem_rd_addr1 = o_mem_rd_en ? addr1_q : {ADDR_WIDTH{1'b0}};
    assign o_mem_wr_addr0 = o_mem_wr_en ? addr0_q : {ADDR_WIDTH{1'b0}};
    assign o_mem_wr_addr1 = o_mem_wr_en ? addr1_q : {ADDR_WIDTH{1'b0}};
    assign o_mem_wr_data0 = o_mem_wr_en ? res0_s : {PSUM_WIDTH{1'b0}};
    assign o_mem_wr_data1 = o_mem_wr_en ? res1_s : {PSUM_WIDTH{1'b0}};
    assign o_done         = done_q;
    assign o_pair_cnt     = cnt_q;

endmodule
